// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_mem_pkg
//  Description : Shared definitions for the data-memory path: access-size
//                (snb) codes, arbiter FSM state encoding and a byte-count
//                helper for the size codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_mem_pkg;

   // Access size codes carried on snb
   localparam logic [1:0] SNB_BYTE = 2'b00;
   localparam logic [1:0] SNB_HALF = 2'b01;
   localparam logic [1:0] SNB_WORD = 2'b10;
   localparam logic [1:0] SNB_RSVD = 2'b11;

   // Arbiter FSM state encoding
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } arb_state_e;

   // Number of bytes touched by an access of the given size.
   // The reserved code reports 4 so range arithmetic stays bounded; such
   // accesses are always flagged as errors anyway.
   function automatic logic [2:0] snb_bytes(input logic [1:0] snb);
      case (snb)
         SNB_BYTE: snb_bytes = 3'd1;
         SNB_HALF: snb_bytes = 3'd2;
         default:  snb_bytes = 3'd4;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-input round-robin arbiter, purely combinational. The
//                caller owns the "last winner" register; this block returns
//                the grant and the value that register should take next.
//  Ports       : req_i[1:0]  request per input
//                last_i      index of the previous winner
//                update_i    arbitration is live this cycle
//                gnt_o[1:0]  one-hot grant (zero when no request)
//                last_o      next value for the caller's last-winner register
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   input  logic       update_i,
   output logic [1:0] gnt_o,
   output logic       last_o
);

   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         // contention: the input that did not win last time gets the grant
         2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
   end

   assign last_o = (update_i && (req_i != 2'b00)) ? gnt_o[1] : last_i;

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares one byte-addressed data memory port between the core
//                load/store unit (port 0) and DMA/debug (port 1). Round-robin
//                arbitration, registered command, one access every 3 cycles,
//                one-cycle ack with registered read data.
//  Config      : DMEM_ARB_CHK_EN - when defined, misaligned half/word accesses
//                and accesses running past MEM_BYTES are flagged with err_o
//                and their write is suppressed.
//  Ports       : clk, rst_n           clock, synchronous active-low reset
//                req_i/we_i[1:0]      per-port request / write enable
//                snb0_i/snb1_i        per-port size (byte/half/word/rsvd)
//                addr0_i/addr1_i      per-port byte address
//                wdata0_i/wdata1_i    per-port write data
//                ack_o[1:0], err_o    one-hot completion pulse and error flag
//                rdata_o              registered memory read data
//                mem_snb_o/we/a/wd    memory command
//                mem_rd_i             memory combinational read data
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MEM_BYTES = 256
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [1:0]    req_i,
   input  logic [1:0]    we_i,
   input  logic [1:0]    snb0_i,
   input  logic [1:0]    snb1_i,
   input  logic [AW-1:0] addr0_i,
   input  logic [AW-1:0] addr1_i,
   input  logic [DW-1:0] wdata0_i,
   input  logic [DW-1:0] wdata1_i,
   output logic [1:0]    ack_o,
   output logic          err_o,
   output logic [DW-1:0] rdata_o,
   output logic [1:0]    mem_snb_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_a_o,
   output logic [DW-1:0] mem_wd_o,
   input  logic [DW-1:0] mem_rd_i
);

   arb_state_e    state_q, state_d;
   logic          last_q, last_d;
   logic [1:0]    gnt;
   logic          port_q;
   logic          we_q;
   logic [1:0]    snb_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wd_q;
   logic [1:0]    ack_q;
   logic          err_q;
   logic [DW-1:0] rdata_q;
   logic          err_w;

   rr_arb2 u_arb (
      .req_i    (req_i),
      .last_i   (last_q),
      .update_i (state_q == ST_IDLE),
      .gnt_o    (gnt),
      .last_o   (last_d)
   );

   // Error evaluation on the latched command
`ifdef DMEM_ARB_CHK_EN
   logic          misalign_w;
   logic [AW:0]   end_addr_w;
   logic          range_w;

   always_comb begin
      misalign_w = ((snb_q == SNB_HALF) && addr_q[0]) ||
                   ((snb_q == SNB_WORD) && (addr_q[1:0] != 2'b00));
      // one extra bit so an address near the top of the space cannot wrap
      end_addr_w = {1'b0, addr_q} + {{(AW-2){1'b0}}, snb_bytes(snb_q)};
      range_w    = end_addr_w > (AW+1)'(MEM_BYTES);
      err_w      = (snb_q == SNB_RSVD) || misalign_w || range_w;
   end
`else
   always_comb begin
      err_w = (snb_q == SNB_RSVD);
   end
`endif

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (req_i != 2'b00) state_d = ST_ACCESS;
         ST_ACCESS: state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b1;
         port_q  <= 1'b0;
         we_q    <= 1'b0;
         snb_q   <= 2'b00;
         addr_q  <= '0;
         wd_q    <= '0;
         ack_q   <= 2'b00;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         case (state_q)
            ST_IDLE: begin
               if (req_i != 2'b00) begin
                  port_q <= gnt[1];
                  we_q   <= gnt[1] ? we_i[1]  : we_i[0];
                  snb_q  <= gnt[1] ? snb1_i   : snb0_i;
                  addr_q <= gnt[1] ? addr1_i  : addr0_i;
                  wd_q   <= gnt[1] ? wdata1_i : wdata0_i;
               end
            end
            ST_ACCESS: begin
               rdata_q <= mem_rd_i;
               ack_q   <= port_q ? 2'b10 : 2'b01;
               err_q   <= err_w;
            end
            ST_RESP: begin
               ack_q <= 2'b00;
               err_q <= 1'b0;
            end
            default: begin
               ack_q <= 2'b00;
               err_q <= 1'b0;
            end
         endcase
      end
   end

   // The write strobe is qualified with rst_n so that a reset arriving
   // during ACCESS kills the write at the same edge the memory would commit.
   assign mem_we_o  = rst_n && (state_q == ST_ACCESS) && we_q && !err_w;
   assign mem_snb_o = snb_q;
   assign mem_a_o   = addr_q;
   assign mem_wd_o  = wd_q;
   assign ack_o     = ack_q;
   assign err_o     = err_q;
   assign rdata_o   = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Bench for dmem_arbiter. A byte-array memory sits on the
//                memory port; a reference byte array plus a round-robin
//                order model predicts ack order, err, read data, write
//                pulses and ack spacing for directed and random rounds.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

   localparam int AW        = 32;
   localparam int DW        = 32;
   localparam int MEM_BYTES = 256;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    req_i, we_i, snb0_i, snb1_i;
   logic [AW-1:0] addr0_i, addr1_i;
   logic [DW-1:0] wdata0_i, wdata1_i;
   logic [1:0]    ack_o;
   logic          err_o;
   logic [DW-1:0] rdata_o;
   logic [1:0]    mem_snb_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_a_o;
   logic [DW-1:0] mem_wd_o;
   logic [DW-1:0] mem_rd_i;

   always #5 clk = ~clk;

   dmem_arbiter #(.AW(AW), .DW(DW), .MEM_BYTES(MEM_BYTES)) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i),
      .snb0_i(snb0_i), .snb1_i(snb1_i), .addr0_i(addr0_i), .addr1_i(addr1_i),
      .wdata0_i(wdata0_i), .wdata1_i(wdata1_i), .ack_o(ack_o), .err_o(err_o),
      .rdata_o(rdata_o), .mem_snb_o(mem_snb_o), .mem_we_o(mem_we_o),
      .mem_a_o(mem_a_o), .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i)
   );

   // ---------------- memory attached to the DUT ----------------
   logic [7:0] tb_mem  [256];
   logic [7:0] ref_mem [256];
   logic       mem_ready;

   function automatic logic [7:0] pat(input int i);
      return 8'((i * 37 + 5) & 255);
   endfunction

   always_comb begin
      mem_rd_i = {tb_mem[mem_a_o[7:0] + 8'd3], tb_mem[mem_a_o[7:0] + 8'd2],
                  tb_mem[mem_a_o[7:0] + 8'd1], tb_mem[mem_a_o[7:0]]};
   end

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) tb_mem[i] <= pat(i);
      end else if (mem_we_o) begin
         tb_mem[mem_a_o[7:0]] <= mem_wd_o[7:0];
         if (mem_snb_o != 2'b00) tb_mem[mem_a_o[7:0] + 8'd1] <= mem_wd_o[15:8];
         if (mem_snb_o == 2'b10) begin
            tb_mem[mem_a_o[7:0] + 8'd2] <= mem_wd_o[23:16];
            tb_mem[mem_a_o[7:0] + 8'd3] <= mem_wd_o[31:24];
         end
      end
   end

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic        m_we  [2];
   logic [1:0]  m_snb [2];
   logic [31:0] m_addr[2];
   logic [31:0] m_wd  [2];
   int          last_m;

   function automatic int nbytes(input logic [1:0] snb);
      return (snb == 2'b00) ? 1 : (snb == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic model_err(input logic [1:0] snb, input logic [31:0] a);
      if (snb == 2'b11) return 1'b1;
`ifdef DMEM_ARB_CHK_EN
      if ((longint'(a) % nbytes(snb)) != 0) return 1'b1;
      if (longint'(a) + nbytes(snb) > MEM_BYTES) return 1'b1;
`endif
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = ref_mem[(longint'(a) + i) % 256];
      return r;
   endfunction

   task automatic ref_write(input logic [1:0] snb, input logic [31:0] a, input logic [31:0] d);
      for (int i = 0; i < nbytes(snb); i++) ref_mem[(longint'(a) + i) % 256] = d[8*i +: 8];
   endtask

   task automatic cmd(input int p, input logic we, input logic [1:0] snb,
                      input logic [31:0] a, input logic [31:0] d);
      m_we[p] = we; m_snb[p] = snb; m_addr[p] = a; m_wd[p] = d;
      we_i[p] = we;
      if (p == 0) begin snb0_i = snb; addr0_i = a; wdata0_i = d; end
      else        begin snb1_i = snb; addr1_i = a; wdata1_i = d; end
   endtask

   // Raise the requests in mask and serve them until all are acked.
   // fresh: the DUT is idle, so the first ack comes 2 edges after raising;
   // otherwise acks are spaced 3 edges apart.
   task automatic run_round(input logic [1:0] mask, input bit fresh);
      logic [1:0]  pend;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          w, cnt, wep;
      bit          first;
      pend  = mask;
      first = 1'b1;
      req_i = mask;
      while (pend != 2'b00) begin
         w      = (pend == 2'b11) ? 1 - last_m : (pend[1] ? 1 : 0);
         last_m = w;
         cnt = 0; wep = 0;
         do begin
            @(posedge clk); #1;
            cnt++;
            if (mem_we_o) wep++;
         end while (ack_o == 2'b00 && cnt < 12);
         if (ack_o == 2'b00) begin
            chk("ack_timeout", 32'(ack_o), 32'(1 << w));
            req_i = 2'b00;
            return;
         end
         exp_err = model_err(m_snb[w], m_addr[w]);
         exp_rd  = ref_read(m_addr[w]);
         chk("ack",       32'(ack_o),  32'(1 << w));
         chk("err",       32'(err_o),  32'(exp_err));
         chk("rdata",     rdata_o,     exp_rd);
         chk("we_pulses", 32'(wep),    (m_we[w] && !exp_err) ? 32'd1 : 32'd0);
         chk("latency",   32'(cnt),    (fresh && first) ? 32'd2 : 32'd3);
         if (m_we[w] && !exp_err) ref_write(m_snb[w], m_addr[w], m_wd[w]);
         req_i[w] = 1'b0;
         pend[w]  = 1'b0;
         first    = 1'b0;
      end
   endtask

   task automatic rand_cmd(input int p);
      logic [1:0]  snb;
      logic [31:0] a;
      int          r;
      snb = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      r   = $urandom_range(0, 15);
      if (r == 0)     a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      else if (r < 9) a = 32'($urandom_range(0, 255)) & ~32'(nbytes(snb) - 1);
      else            a = 32'($urandom_range(0, 255));
      cmd(p, 1'($urandom_range(0, 1)), snb, a, $urandom);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; req_i = 2'b00; mem_ready = 1'b0; last_m = 1;
      for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
      cmd(0, 1'b0, 2'b00, 32'h0, 32'h0);
      cmd(1, 1'b0, 2'b00, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      mem_ready = 1'b1;
      chk("rst_ack",   32'(ack_o),     32'h0);
      chk("rst_err",   32'(err_o),     32'h0);
      chk("rst_rdata", rdata_o,        32'h0);
      chk("rst_we",    32'(mem_we_o),  32'h0);
      chk("rst_a",     mem_a_o,        32'h0);
      chk("rst_wd",    mem_wd_o,       32'h0);
      chk("rst_snb",   32'(mem_snb_o), 32'h0);
      rst_n = 1'b1;

      // both ports contending from reset: grants 0,1,0,1
      cmd(0, 1'b0, 2'b10, 32'h10, 32'h0);
      cmd(1, 1'b1, 2'b00, 32'h20, 32'h5A);
      run_round(2'b11, 1'b1);
      run_round(2'b11, 1'b0);
      // port0 word write then readback
      cmd(0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF);
      run_round(2'b01, 1'b0);
      cmd(0, 1'b0, 2'b10, 32'h10, 32'h0);
      run_round(2'b01, 1'b0);
      // port1 byte write into the word, then word read
      cmd(1, 1'b1, 2'b00, 32'h11, 32'hAA);
      run_round(2'b10, 1'b0);
      cmd(0, 1'b0, 2'b10, 32'h10, 32'h0);
      run_round(2'b01, 1'b0);
      // reserved size write
      cmd(0, 1'b1, 2'b11, 32'h30, 32'h12345678);
      run_round(2'b01, 1'b0);
      cmd(0, 1'b0, 2'b10, 32'h30, 32'h0);
      run_round(2'b01, 1'b0);

      // reset during ACCESS of a write to 0x40
      @(posedge clk); #1;
      cmd(0, 1'b1, 2'b10, 32'h40, 32'h11223344);
      req_i = 2'b01;
      @(posedge clk); #1;
      chk("abort_we_in_access", 32'(mem_we_o), 32'h1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      req_i = 2'b00;
      chk("abort_ack",   32'(ack_o),     32'h0);
      chk("abort_err",   32'(err_o),     32'h0);
      chk("abort_rdata", rdata_o,        32'h0);
      chk("abort_we",    32'(mem_we_o),  32'h0);
      chk("abort_a",     mem_a_o,        32'h0);
      chk("abort_wd",    mem_wd_o,       32'h0);
      chk("abort_snb",   32'(mem_snb_o), 32'h0);
      chk("abort_mem40", {tb_mem[8'h43], tb_mem[8'h42], tb_mem[8'h41], tb_mem[8'h40]},
          ref_read(32'h40));
      rst_n  = 1'b1;
      last_m = 1;

      // misaligned word write and half write at the top byte
      cmd(0, 1'b1, 2'b10, 32'h13, 32'hCAFEF00D);
      cmd(1, 1'b1, 2'b01, 32'hFF, 32'h0000B00C);
      run_round(2'b11, 1'b1);

      for (int n = 0; n < 150; n++) begin
         rand_cmd(0);
         rand_cmd(1);
         run_round(2'($urandom_range(1, 3)), 1'b0);
      end

      @(posedge clk); #1;
      for (int i = 0; i < 256; i++) chk($sformatf("mem[%0d]", i), 32'(tb_mem[i]), 32'(ref_mem[i]));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
